// File: rtl/direct_cache_refill_if.sv
// Cache-refill bus: miss request from the cache, beat reads to backing memory,
// and the assembled line handed back to the cache.
interface direct_cache_refill_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_WIDTH  = 32
);
  logic                    miss_valid;
  logic                    miss_ready;
  logic [ADDR_WIDTH-1:0]   miss_addr;
  logic                    mem_rd_req;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr;
  logic                    mem_rd_ack;
  logic [MEM_WIDTH-1:0]    mem_rd_data;
  logic                    fill_valid;
  logic                    fill_ready;
  logic [ADDR_WIDTH-1:0]   fill_addr;
  logic [BLOCK_SIZE*8-1:0] fill_data;

  // Refill engine's view.
  modport master (
    input  miss_valid, miss_addr, mem_rd_ack, mem_rd_data, fill_ready,
    output miss_ready, mem_rd_req, mem_rd_addr, fill_valid, fill_addr, fill_data
  );

  // Cache / memory side's view.
  modport slave (
    output miss_valid, miss_addr, mem_rd_ack, mem_rd_data, fill_ready,
    input  miss_ready, mem_rd_req, mem_rd_addr, fill_valid, fill_addr, fill_data
  );
endinterface

// File: rtl/direct_cache_refill.sv
// Direct-mapped cache line refill engine: fetches one line as BEATS memory
// reads, assembles it, and holds it until the cache takes it.
module direct_cache_refill #(
  parameter int ADDR_WIDTH = 16,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  direct_cache_refill_if.master bus,
  output logic [31:0]           refill_count
);
  localparam int BEATS  = BLOCK_SIZE * 8 / MEM_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(MEM_WIDTH / 8);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

  state_t                  state, state_next;
  logic [BEAT_W-1:0]       beat;
  logic [ADDR_WIDTH-1:0]   line_addr;
  logic [BLOCK_SIZE*8-1:0] line_data;
  logic [31:0]             count_q;
  logic                    accept, beat_ack, fill_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    beat_ack       = 1'b0;
    fill_done      = 1'b0;
    bus.miss_ready = 1'b0;
    bus.mem_rd_req = 1'b0;
    bus.fill_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.miss_ready = 1'b1;
        if (bus.miss_valid) begin
          accept     = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        bus.mem_rd_req = 1'b1;
        if (bus.mem_rd_ack) begin
          beat_ack = 1'b1;
          if (beat == LAST_BEAT) state_next = DELIVER;
        end
      end
      DELIVER: begin
        bus.fill_valid = 1'b1;
        if (bus.fill_ready) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address is only driven while fetching so it reads 0 in reset/idle.
  assign bus.mem_rd_addr = (state == FETCH) ? line_addr + ADDR_WIDTH'(beat) * BEAT_BYTES : '0;
  assign bus.fill_addr   = line_addr;
  assign bus.fill_data   = line_data;
  assign refill_count    = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat      <= '0;
      line_addr <= '0;
      line_data <= '0;
      count_q   <= '0;
    end else begin
      if (accept) begin
        line_addr <= bus.miss_addr & LINE_MASK;
        beat      <= '0;
      end
      if (beat_ack) begin
        for (int unsigned i = 0; i < BEATS; i++) begin
          if (beat == BEAT_W'(i)) line_data[i*MEM_WIDTH +: MEM_WIDTH] <= bus.mem_rd_data;
        end
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
      if (fill_done) count_q <= count_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_direct_cache_refill.sv
// Self-checking bench for direct_cache_refill: directed vector table, corner
// sequences (reset mid-fetch, queued misses, counter wrap) and random refills.
module tb_direct_cache_refill;
  logic        clk;
  logic        reset;
  logic [31:0] refill_count;

  direct_cache_refill_if #(.ADDR_WIDTH(16), .BLOCK_SIZE(16), .MEM_WIDTH(32)) bus ();

  direct_cache_refill #(.ADDR_WIDTH(16), .BLOCK_SIZE(16), .MEM_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .refill_count (refill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_count;

  typedef struct {
    logic [15:0]  addr;
    int           waits;
    int           bp;
    logic [127:0] line;
    logic [15:0]  exp_addr;
    logic [127:0] exp_data;
    int           exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.miss_valid  = 1'b0;
    bus.miss_addr   = '0;
    bus.mem_rd_ack  = 1'b0;
    bus.mem_rd_data = '0;
    bus.fill_ready  = 1'b0;
  endtask

  // One complete refill; the bench plays the memory, answering each request
  // after 'waits' idle cycles, then stalls the cache for 'bp' cycles.
  task automatic run_fill(input logic [15:0] addr, input int waits, input int bp,
                          input logic [127:0] line, input logic [15:0] exp_addr,
                          input logic [127:0] exp_data, input int exp_lat,
                          input bit queue_next, input logic [15:0] next_addr);
    int cyc, b, w, addr_err, busy_err, hold_err;
    check("miss_ready_before_accept", 128'(bus.miss_ready), 128'(1));
    bus.miss_valid  = 1'b1;
    bus.miss_addr   = addr;
    bus.mem_rd_ack  = 1'b1;
    bus.mem_rd_data = 32'hBAD0BAD0;
    tick();
    bus.miss_valid = 1'b0;
    bus.miss_addr  = ~addr;
    cyc = 0; b = 0; w = 0; addr_err = 0; busy_err = 0;
    while (bus.fill_valid !== 1'b1 && cyc < 400) begin
      if (bus.miss_ready !== 1'b0) busy_err++;
      if (bus.mem_rd_req === 1'b1) begin
        if (bus.mem_rd_addr !== exp_addr + 16'(4 * b)) addr_err++;
        if (w < waits) begin
          bus.mem_rd_ack = 1'b0;
          w++;
        end else begin
          bus.mem_rd_ack  = 1'b1;
          bus.mem_rd_data = (b < 4) ? line[b*32 +: 32] : 32'h0;
          b++;
          w = 0;
        end
      end else begin
        bus.mem_rd_ack = 1'b0;
        busy_err++;
      end
      tick();
      cyc++;
    end
    bus.mem_rd_ack = 1'b0;
    check("fill_valid_seen", 128'(bus.fill_valid), 128'(1));
    check("fill_latency", 128'(cyc), 128'(exp_lat));
    check("beat_addr_errors", 128'(addr_err), 128'(0));
    check("busy_output_errors", 128'(busy_err), 128'(0));
    check("beats_acked", 128'(b), 128'(4));
    check("fill_addr", 128'(bus.fill_addr), 128'(exp_addr));
    check("fill_data", bus.fill_data, exp_data);

    hold_err = 0;
    for (int i = 0; i < bp; i++) begin
      bus.miss_valid  = 1'b1;
      bus.miss_addr   = queue_next ? next_addr : (addr ^ 16'h0100);
      bus.mem_rd_ack  = 1'b1;
      bus.mem_rd_data = 32'hDEADBEEF;
      if (bus.fill_valid !== 1'b1 || bus.fill_addr !== exp_addr || bus.fill_data !== exp_data ||
          bus.miss_ready !== 1'b0 || bus.mem_rd_req !== 1'b0) hold_err++;
      tick();
    end
    if (bp > 0) check("backpressure_hold_errors", 128'(hold_err), 128'(0));

    bus.miss_valid = queue_next;
    bus.miss_addr  = next_addr;
    bus.mem_rd_ack = 1'b0;
    bus.fill_ready = 1'b1;
    tick();
    bus.fill_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    check("post_fill_valid", 128'(bus.fill_valid), 128'(0));
    check("post_fill_miss_ready", 128'(bus.miss_ready), 128'(1));
    check("post_fill_mem_rd_req", 128'(bus.mem_rd_req), 128'(0));
    check("refill_count", 128'(refill_count), 128'(exp_count));
  endtask

  initial begin
    logic [15:0]  r_addr;
    logic [127:0] r_line;
    int           r_waits, r_bp;

    vecs[0] = '{16'h0123, 0, 0, 128'h44444444333333332222222211111111,
                16'h0120, 128'h44444444333333332222222211111111, 4};
    vecs[1] = '{16'h0ABF, 3, 0, 128'hCAFEF00D0123456789ABCDEFDEADBEEF,
                16'h0AB0, 128'hCAFEF00D0123456789ABCDEFDEADBEEF, 16};
    vecs[2] = '{16'hFFFF, 1, 5, 128'h0F0F0F0FF0F0F0F0AAAA55555555AAAA,
                16'hFFF0, 128'h0F0F0F0FF0F0F0F0AAAA55555555AAAA, 8};
    vecs[3] = '{16'h0000, 0, 2, 128'h00000000000000000000000000000001,
                16'h0000, 128'h00000000000000000000000000000001, 4};
    vecs[4] = '{16'h8008, 2, 1, 128'h13579BDF2468ACE0FEDCBA9876543210,
                16'h8000, 128'h13579BDF2468ACE0FEDCBA9876543210, 12};

    idle_inputs();
    reset     = 1'b1;
    exp_count = 32'd0;
    #3;
    check("reset_miss_ready", 128'(bus.miss_ready), 128'(1));
    check("reset_mem_rd_req", 128'(bus.mem_rd_req), 128'(0));
    check("reset_mem_rd_addr", 128'(bus.mem_rd_addr), 128'(0));
    check("reset_fill_valid", 128'(bus.fill_valid), 128'(0));
    check("reset_fill_addr", 128'(bus.fill_addr), 128'(0));
    check("reset_fill_data", bus.fill_data, 128'(0));
    check("reset_refill_count", 128'(refill_count), 128'(0));
    #19 reset = 1'b0;
    tick();

    // Reset while two beats into a fetch.
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 16'h0247;
    tick();
    bus.miss_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.mem_rd_ack  = 1'b1;
      bus.mem_rd_data = $urandom;
      tick();
    end
    bus.mem_rd_ack = 1'b0;
    check("midfetch_req", 128'(bus.mem_rd_req), 128'(1));
    check("midfetch_addr", 128'(bus.mem_rd_addr), 128'(16'h0248));
    #2 reset = 1'b1;
    #1;
    check("abort_mem_rd_req", 128'(bus.mem_rd_req), 128'(0));
    check("abort_fill_valid", 128'(bus.fill_valid), 128'(0));
    check("abort_miss_ready", 128'(bus.miss_ready), 128'(1));
    check("abort_fill_data", bus.fill_data, 128'(0));
    check("abort_refill_count", 128'(refill_count), 128'(0));
    #2 reset = 1'b0;
    run_fill(16'h0247, 0, 0, 128'hA5A5A5A5_5A5A5A5A_0000FFFF_FFFF0000, 16'h0240,
             128'hA5A5A5A5_5A5A5A5A_0000FFFF_FFFF0000, 4, 1'b0, 16'h0);

    foreach (vecs[i])
      run_fill(vecs[i].addr, vecs[i].waits, vecs[i].bp, vecs[i].line,
               vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_lat, 1'b0, 16'h0);

    // Stray acks while idle must not disturb anything.
    bus.mem_rd_ack  = 1'b1;
    bus.mem_rd_data = 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stray_ack_mem_rd_req", 128'(bus.mem_rd_req), 128'(0));
      check("stray_ack_miss_ready", 128'(bus.miss_ready), 128'(1));
    end
    bus.mem_rd_ack = 1'b0;
    check("stray_ack_fill_data", bus.fill_data, vecs[4].exp_data);

    // Two queued misses: the second is held on miss_valid through the first handshake.
    run_fill(16'h0010, 0, 3, 128'h0000000400000003000000020000000_1, 16'h0010,
             128'h00000004000000030000000200000001, 4, 1'b1, 16'h0020);
    run_fill(16'h0020, 1, 0, 128'h80000004800000038000000280000001, 16'h0020,
             128'h80000004800000038000000280000001, 8, 1'b0, 16'h0);

    for (int n = 0; n < 20; n++) begin
      r_addr  = 16'($urandom);
      r_line  = {$urandom, $urandom, $urandom, $urandom};
      r_waits = int'($urandom_range(0, 3));
      r_bp    = int'($urandom_range(0, 3));
      run_fill(r_addr, r_waits, r_bp, r_line, (r_addr / 16'd16) * 16'd16, r_line,
               4 * (r_waits + 1), 1'b0, 16'h0);
    end

    // Counter wrap.
    #2 force dut.count_q = 32'hFFFFFFFF;
    #1 release dut.count_q;
    exp_count = 32'hFFFFFFFF;
    check("preload_count", 128'(refill_count), 128'(exp_count));
    #1;
    run_fill(16'h1234, 0, 0, 128'h1, 16'h1230, 128'h1, 4, 1'b0, 16'h0);
    check("wrapped_count", 128'(refill_count), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/direct_cache_refill.md
DIRECT_CACHE_REFILL -- requirements
Module: direct_cache_refill

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-002 The block SHALL have parameter BLOCK_SIZE, default 16, line size in bytes (power of 2, multiple of 4).
REQ-003 The block SHALL have parameter MEM_WIDTH, default 32, backing-memory data width in bits; BEATS = BLOCK_SIZE*8/MEM_WIDTH.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 miss_valid  input  1  cache presents a line-refill request.
REQ-007 miss_ready  output  1  block can accept a refill request.
REQ-008 miss_addr  input  ADDR_WIDTH  byte address of the missing access.
REQ-009 mem_rd_req  output  1  read request to backing memory.
REQ-010 mem_rd_addr  output  ADDR_WIDTH  byte address of current beat.
REQ-011 mem_rd_ack  input  1  memory returns mem_rd_data this cycle.
REQ-012 mem_rd_data  input  MEM_WIDTH  beat read data.
REQ-013 fill_valid  output  1  assembled line available to the cache.
REQ-014 fill_ready  input  1  cache accepts the line.
REQ-015 fill_addr  output  ADDR_WIDTH  line-aligned address of the filled line.
REQ-016 fill_data  output  BLOCK_SIZE*8  assembled line.
REQ-017 refill_count  output  32  number of completed fills.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DELIVER; miss_ready SHALL be 1 only in IDLE.
REQ-019 A miss SHALL be accepted on a rising edge with miss_valid=1 and miss_ready=1; the block SHALL latch miss_addr with low log2(BLOCK_SIZE) bits forced to 0, clear the beat counter, and enter FETCH.
REQ-020 In FETCH, mem_rd_req SHALL be 1 and mem_rd_addr SHALL equal line base + beat*(MEM_WIDTH/8), stable until the acking edge.
REQ-021 On an edge with mem_rd_ack=1 in FETCH, mem_rd_data SHALL be written to fill_data bits [beat*MEM_WIDTH +: MEM_WIDTH] and beat SHALL increment.
REQ-022 On the ack of beat BEATS-1, the FSM SHALL enter DELIVER; otherwise it SHALL stay in FETCH with mem_rd_req held at 1 (no idle cycle between beats).
REQ-023 mem_rd_ack SHALL be ignored outside FETCH; mem_rd_req SHALL be 0 in IDLE and DELIVER.
REQ-024 Memory wait cycles (mem_rd_req=1, mem_rd_ack=0) SHALL be unbounded; no timeout.
REQ-025 In DELIVER, fill_valid SHALL be 1 with fill_addr and fill_data stable until fill_ready=1 at an edge.
REQ-026 On the fill handshake edge, refill_count SHALL increment (wrapping 2^32-1 -> 0) and the FSM SHALL return to IDLE.
REQ-027 Minimum latency: accept at edge T, zero-wait acks -> fill_valid=1 after edge T+BEATS (4 cycles at defaults).
REQ-028 miss_addr and miss_valid changes outside IDLE SHALL have no effect; a new request SHALL NOT be accepted on the fill handshake edge (earliest next edge).
REQ-029 fill_ready while fill_valid=0 SHALL have no effect.

Reset
REQ-030 reset=1 SHALL immediately, independent of clk, force IDLE, miss_ready=1, mem_rd_req=0, mem_rd_addr=0, fill_valid=0, fill_addr=0, fill_data=0, refill_count=0, beat=0.
REQ-031 Reset during FETCH or DELIVER SHALL abandon the refill with no fill delivered and refill_count not incremented; the first edge after release SHALL be able to accept a request.

Verification
REQ-032 Zero-wait fill: miss_addr=16'h0123, memory returns 32'h11111111,22222222,33333333,44444444 with ack each cycle -> mem_rd_addr 0120,0124,0128,012C; fill_data=128'h44444444333333332222222211111111, fill_addr=16'h0120 after 4 cycles; refill_count=1 after handshake.
REQ-033 Wait states: 3 idle cycles before each ack -> mem_rd_addr held per beat, fill_valid after 16 cycles, data correct.
REQ-034 Backpressure: fill_ready=0 for 5 cycles in DELIVER -> fill_valid, fill_addr, fill_data stable; miss_valid=1 with other address not accepted; miss_ready=1 only on the cycle after handshake.
REQ-035 Reset mid-FETCH after 2 beats -> mem_rd_req=0 and fill_valid=0 immediately; refill_count stays 0; next request fetches from beat 0.
REQ-036 Back-to-back: two queued misses 16'h0010 and 16'h0020 -> two fills, fill_addr 0010 then 0020, refill_count=2, stray mem_rd_ack in IDLE ignored.
REQ-037 Wrap: preload refill_count to 32'hFFFFFFFF via force, complete one fill -> refill_count=0.
